// File: rtl/datapath_bus.sv
// Registered shared-bus mux: lowest-index driver wins, sticky contention flag, saturating transfer count.
// Latency 1 clock, no combinational input-to-output path; no backpressure (a source drives by holding its enable).
module datapath_bus #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NSRC      = 24,
    parameter int unsigned HOLD_LAST = 0,
    parameter int unsigned CNTW      = 16,
    localparam int unsigned SELW     = $clog2(NSRC)
) (
    input  logic                   i_clock,
    input  logic                   i_clear,
    input  logic [NSRC*WIDTH-1:0]  i_src_data,
    input  logic [NSRC-1:0]        i_src_out,
    input  logic                   i_contention_clr,
    output logic [WIDTH-1:0]       o_bus_out,
    output logic                   o_bus_valid,
    output logic [SELW-1:0]        o_src_id,
    output logic                   o_contention,
    output logic [CNTW-1:0]        o_xfer_count
);

    generate
        if (NSRC < 2 || NSRC > 64) begin : g_bad_nsrc
            $error("datapath_bus: NSRC must be in 2..64");
        end
    endgenerate

    localparam logic [NSRC-1:0] ONE_SRC = {{(NSRC-1){1'b0}}, 1'b1};

    logic [SELW-1:0]  w_winner;
    logic [WIDTH-1:0] w_win_dat;
    logic             w_hit;
    logic             w_more;
    logic             w_cnt_sat;

    logic [WIDTH-1:0] r_bus_out;
    logic             r_bus_valid;
    logic [SELW-1:0]  r_src_id;
    logic             r_contention;
    logic [CNTW-1:0]  r_xfer_count;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        w_winner  = '0;
        w_win_dat = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (i_src_out[i]) begin
                w_winner  = SELW'(i);
                w_win_dat = i_src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_hit     = |i_src_out;
    assign w_more    = |(i_src_out & (i_src_out - ONE_SRC));
    assign w_cnt_sat = &r_xfer_count;

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_bus_out    <= '0;
            r_bus_valid  <= 1'b0;
            r_src_id     <= '0;
            r_contention <= 1'b0;
            r_xfer_count <= '0;
        end else begin
            if (w_hit) begin
                r_bus_out   <= w_win_dat;
                r_bus_valid <= 1'b1;
                r_src_id    <= w_winner;
                if (!w_cnt_sat) begin
                    r_xfer_count <= r_xfer_count + CNTW'(1);
                end
            end else begin
                r_bus_valid <= 1'b0;
                if (HOLD_LAST == 0) begin
                    r_bus_out <= '0;
                end
            end
            // A new collision outranks a same-cycle clear request.
            if (w_more) begin
                r_contention <= 1'b1;
            end else if (i_contention_clr) begin
                r_contention <= 1'b0;
            end
        end
    end

    assign o_bus_out    = r_bus_out;
    assign o_bus_valid  = r_bus_valid;
    assign o_src_id     = r_src_id;
    assign o_contention = r_contention;
    assign o_xfer_count = r_xfer_count;

endmodule

// File: tb/tb_datapath_bus.sv
// Bench for datapath_bus: three 32x24 instances (hold-zero, hold-last, 4-bit counter) plus an 8x5 instance.
module tb_datapath_bus;

    localparam int W = 32;
    localparam int N = 24;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    logic [N*W-1:0] src_data = '0;
    logic [N-1:0]   src_out  = '0;
    logic           cclr     = 1'b0;

    logic [31:0] a_bus  [3];
    logic        a_vld  [3];
    logic [4:0]  a_id   [3];
    logic        a_cont [3];
    logic [15:0] a_cnt  [3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    assign a_cnt[0] = cnt0;
    assign a_cnt[1] = cnt1;
    assign a_cnt[2] = {12'h000, cnt2};

    logic [39:0] s_data = '0;
    logic [4:0]  s_out  = '0;
    logic        s_clr  = 1'b0;
    logic [7:0]  s_bus;
    logic        s_vld;
    logic [2:0]  s_id;
    logic        s_cont;
    logic [15:0] s_cnt;

    datapath_bus #(.WIDTH(32), .NSRC(24), .HOLD_LAST(0), .CNTW(16)) u0 (
        .i_clock(clock), .i_clear(clear), .i_src_data(src_data), .i_src_out(src_out),
        .i_contention_clr(cclr), .o_bus_out(a_bus[0]), .o_bus_valid(a_vld[0]),
        .o_src_id(a_id[0]), .o_contention(a_cont[0]), .o_xfer_count(cnt0));

    datapath_bus #(.WIDTH(32), .NSRC(24), .HOLD_LAST(1), .CNTW(16)) u1 (
        .i_clock(clock), .i_clear(clear), .i_src_data(src_data), .i_src_out(src_out),
        .i_contention_clr(cclr), .o_bus_out(a_bus[1]), .o_bus_valid(a_vld[1]),
        .o_src_id(a_id[1]), .o_contention(a_cont[1]), .o_xfer_count(cnt1));

    datapath_bus #(.WIDTH(32), .NSRC(24), .HOLD_LAST(0), .CNTW(4)) u2 (
        .i_clock(clock), .i_clear(clear), .i_src_data(src_data), .i_src_out(src_out),
        .i_contention_clr(cclr), .o_bus_out(a_bus[2]), .o_bus_valid(a_vld[2]),
        .o_src_id(a_id[2]), .o_contention(a_cont[2]), .o_xfer_count(cnt2));

    datapath_bus #(.WIDTH(8), .NSRC(5), .HOLD_LAST(0), .CNTW(16)) u3 (
        .i_clock(clock), .i_clear(clear), .i_src_data(s_data), .i_src_out(s_out),
        .i_contention_clr(s_clr), .o_bus_out(s_bus), .o_bus_valid(s_vld),
        .o_src_id(s_id), .o_contention(s_cont), .o_xfer_count(s_cnt));

    // Reference model for u0..u2, written from the bus rules rather than the RTL structure.
    logic [31:0] m_bus  [3];
    bit          m_vld  [3];
    int          m_id   [3];
    bit          m_cont [3];
    int          m_cnt  [3];
    const int    cmax   [3] = '{65535, 65535, 15};
    const bit    hold   [3] = '{1'b0, 1'b1, 1'b0};

    always @(posedge clock or posedge clear) begin : model
        int n, w;
        n = $countones(src_out);
        w = 0;
        while (w < N && !src_out[w]) w++;
        for (int k = 0; k < 3; k++) begin
            if (clear) begin
                m_bus[k] = '0; m_vld[k] = 0; m_id[k] = 0; m_cont[k] = 0; m_cnt[k] = 0;
            end else begin
                if (n > 0) begin
                    m_bus[k] = src_data[w*W +: W];
                    m_vld[k] = 1;
                    m_id[k]  = w;
                    if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                end else begin
                    m_vld[k] = 0;
                    if (!hold[k]) m_bus[k] = '0;
                end
                if (n > 1) m_cont[k] = 1;
                else if (cclr) m_cont[k] = 0;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_main();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d bus_out", k),    64'(a_bus[k]),  64'(m_bus[k]));
            chk($sformatf("u%0d bus_valid", k),  64'(a_vld[k]),  64'(m_vld[k]));
            chk($sformatf("u%0d src_id", k),     64'(a_id[k]),   64'(m_id[k]));
            chk($sformatf("u%0d contention", k), 64'(a_cont[k]), 64'(m_cont[k]));
            chk($sformatf("u%0d xfer_count", k), 64'(a_cnt[k]),  64'(m_cnt[k]));
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
        check_main();
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #3 clear = 1'b1;
        #1 check_main();
        #3 clear = 1'b0;
    endtask

    task automatic rand_data();
        for (int j = 0; j < N; j++) src_data[j*W +: W] = $urandom;
    endtask

    typedef struct {
        logic [4:0]  out;
        logic [39:0] dat;
        logic        clr;
        logic [7:0]  bus;
        logic        vld;
        logic [2:0]  id;
        logic        cont;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{5'b10000, 40'h9C_AA_BB_CC_DD, 1'b0, 8'h9C, 1'b1, 3'd4, 1'b0, 16'd1};
        tbl[1] = '{5'b00001, 40'hEE_FF_01_02_11, 1'b0, 8'h11, 1'b1, 3'd0, 1'b0, 16'd2};
        tbl[2] = '{5'b00110, 40'h00_00_32_21_99, 1'b0, 8'h21, 1'b1, 3'd1, 1'b1, 16'd3};
        tbl[3] = '{5'b00000, 40'h12_34_56_78_9A, 1'b1, 8'h00, 1'b0, 3'd1, 1'b0, 16'd3};
        tbl[4] = '{5'b11000, 40'h66_47_00_00_00, 1'b1, 8'h47, 1'b1, 3'd3, 1'b1, 16'd4};
        tbl[5] = '{5'b00000, 40'hFF_FF_FF_FF_FF, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 16'd4};
        tbl[6] = '{5'b00100, 40'h01_02_5A_03_04, 1'b0, 8'h5A, 1'b1, 3'd2, 1'b1, 16'd5};

        #1 clear = 1'b1;
        #1;
        check_main();
        chk("u3 reset bus", 64'(s_bus), 64'h0);
        chk("u3 reset cnt", 64'(s_cnt), 64'h0);
        @(posedge clock);
        #2 clear = 1'b0;

        // Odd-parameter instance, table driven.
        for (int r = 0; r < 7; r++) begin
            s_out  = tbl[r].out;
            s_data = tbl[r].dat;
            s_clr  = tbl[r].clr;
            step();
            chk($sformatf("u3 row%0d bus", r),  64'(s_bus),  64'(tbl[r].bus));
            chk($sformatf("u3 row%0d vld", r),  64'(s_vld),  64'(tbl[r].vld));
            chk($sformatf("u3 row%0d id", r),   64'(s_id),   64'(tbl[r].id));
            chk($sformatf("u3 row%0d cont", r), 64'(s_cont), 64'(tbl[r].cont));
            chk($sformatf("u3 row%0d cnt", r),  64'(s_cnt),  64'(tbl[r].cnt));
        end
        s_out = '0;
        s_clr = 1'b0;

        // Single-source sweep from a fresh counter.
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            rand_data();
            src_data[i*W +: W] = 32'hA500_0000 + 32'(i);
            src_out = '0;
            src_out[i] = 1'b1;
            step();
            chk("sweep bus", 64'(a_bus[0]), 64'(32'hA500_0000 + 32'(i)));
            chk("sweep id", 64'(a_id[0]), 64'(i));
            chk("sweep cont", 64'(a_cont[0]), 64'h0);
        end
        chk("sweep count", 64'(a_cnt[0]), 64'd24);

        // Contention: set, sticky, clear, and set-beats-clear.
        rand_data();
        src_data[2*W +: W] = 32'h2222_2222;
        src_data[5*W +: W] = 32'h5555_5555;
        src_out = 24'h000024;
        step();
        chk("cont bus", 64'(a_bus[0]), 64'h2222_2222);
        chk("cont id", 64'(a_id[0]), 64'd2);
        chk("cont flag", 64'(a_cont[0]), 64'h1);
        src_out = 24'h000080;
        step();
        chk("cont sticky", 64'(a_cont[0]), 64'h1);
        src_out = '0;
        cclr = 1'b1;
        step();
        chk("cont cleared", 64'(a_cont[0]), 64'h0);
        src_out = 24'h000003;
        step();
        chk("cont set wins", 64'(a_cont[0]), 64'h1);
        cclr = 1'b0;

        // Idle behaviour in both hold modes.
        src_data[9*W +: W] = 32'h1234_5678;
        src_out = 24'h000200;
        step();
        src_out = '0;
        rand_data();
        step();
        chk("idle bus hold0", 64'(a_bus[0]), 64'h0);
        chk("idle bus hold1", 64'(a_bus[1]), 64'h1234_5678);
        chk("idle vld hold0", 64'(a_vld[0]), 64'h0);
        chk("idle vld hold1", 64'(a_vld[1]), 64'h0);
        chk("idle id hold0", 64'(a_id[0]), 64'd9);
        chk("idle id hold1", 64'(a_id[1]), 64'd9);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            int sel;
            rand_data();
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                src_out = '0;
            end else if (sel == 2) begin
                src_out = N'($urandom);
            end else begin
                src_out = '0;
                src_out[$urandom_range(0, N-1)] = 1'b1;
            end
            cclr = ($urandom_range(0, 7) == 0);
            step();
        end
        cclr = 1'b0;

        // Mid-cycle asynchronous clear discards the in-flight sample.
        src_out = 24'h000001;
        src_data[31:0] = 32'hDEAD_BEEF;
        @(posedge clock);
        #3 clear = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("clr u%0d bus", k),  64'(a_bus[k]),  64'h0);
            chk($sformatf("clr u%0d vld", k),  64'(a_vld[k]),  64'h0);
            chk($sformatf("clr u%0d id", k),   64'(a_id[k]),   64'h0);
            chk($sformatf("clr u%0d cont", k), 64'(a_cont[k]), 64'h0);
            chk($sformatf("clr u%0d cnt", k),  64'(a_cnt[k]),  64'h0);
        end
        #3 clear = 1'b0;
        step();
        chk("post-clear bus", 64'(a_bus[0]), 64'hDEAD_BEEF);
        chk("post-clear id", 64'(a_id[0]), 64'h0);
        chk("post-clear vld", 64'(a_vld[0]), 64'h1);

        // Counter saturation on the 4-bit instance.
        src_out = 24'h800000;
        for (int c = 0; c < 20; c++) step();
        chk("sat count", 64'(a_cnt[2]), 64'hF);
        chk("sat id", 64'(a_id[2]), 64'd23);
        chk("wide count", 64'(a_cnt[0]), 64'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_bus.md
# datapath_bus

Parametrised, registered shared-bus multiplexer for the CPU datapath: NSRC sources (registers, HI/LO, Z halves, PC, MDR, in-port, sign-extended constant) present data, each with a drive enable, and the block places the winning source on a registered bus. Compared with the combinational bus mux it replaces, it:
- generalises data width and source count;
- resolves multi-driver contention by fixed priority and flags it with a sticky bit;
- optionally holds the last bus value when no source drives;
- reports the captured source ID and a saturating transfer count for debug and verification.

## Interface
- WIDTH, 32, data width of each source and of the bus
- NSRC, 24, number of bus sources (2..64)
- HOLD_LAST, 0, when no source drives: 0 = bus goes to zero, 1 = bus keeps its previous value
- CNTW, 16, width of the transfer counter
- SELW, derived $clog2(NSRC), width of the source ID
- clock  in  1  system clock, all state on rising edge
- clear  in  1  asynchronous, active-high reset
- src_data  in  NSRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
- src_out  in  NSRC  drive enables, bit i = source i requests the bus (intended one-hot)
- contention_clr  in  1  synchronous clear of the sticky contention flag
- bus_out  out  WIDTH  registered bus value
- bus_valid  out  1  a source drove the bus in the previous cycle
- src_id  out  SELW  index of the source captured into bus_out
- contention  out  1  sticky, set when more than one src_out bit was high in any cycle
- xfer_count  out  CNTW  saturating count of cycles with at least one driver

## Operation
- Priority encoder over src_out: lowest set index wins (index 0 highest priority). Its output is the winner index plus a hit = |src_out.
- Multi-driver detect: more = src_out has two or more bits set. Implement it as (src_out & (src_out - 1)) != 0 or an equivalent.
- The winning source's data slice is selected combinationally and registered each cycle.
- When hit = 1:
  - bus_out <= src_data[winner]
  - src_id <= winner
  - bus_valid <= 1
  - xfer_count increments unless it is already all ones (saturates, no wrap)
- When hit = 0:
  - bus_valid <= 0
  - src_id holds its value
  - xfer_count holds its value
  - bus_out <= 0 if HOLD_LAST = 0; bus_out holds if HOLD_LAST = 1
- contention:
  - set when more = 1
  - cleared when contention_clr = 1 and more = 0
  - if both are 1 in the same cycle, set wins
  - otherwise holds
- src_data of non-winning sources never affects any output.
- NSRC is not required to be a power of two. src_id values ≥ NSRC never occur.

## Timing
- All outputs are registered. Latency is 1 clock: inputs sampled at edge k appear on outputs after edge k.
- No handshake. A source drives by holding its src_out bit high; every cycle it is high counts as one transfer.
- Back-to-back transfers from different sources in consecutive cycles are supported at full rate, with no bubbles.
- Asynchronous clear, immediate, independent of clock:
  - bus_out = 0
  - bus_valid = 0
  - src_id = 0
  - contention = 0
  - xfer_count = 0
- Clear asserted mid-transfer discards the in-flight sample. The first edge after clear deasserts behaves as a normal cycle.
- src_out = 0 for the whole time after reset: bus_out stays 0 in both HOLD_LAST modes.
- Maximum combinational path: priority encoder plus NSRC:1 data mux. No combinational path exists from any input to any output.

## Test plan
- Reset: assert clear mid-cycle with src_out = 24'h000001 and src_data[0] = 32'hDEADBEEF -> all outputs 0 immediately. The first edge after release gives bus_out = 32'hDEADBEEF, src_id = 0, bus_valid = 1.
- Single-source sweep: drive one-hot src_out = 1<<i with src_data[i] = 32'hA5000000 + i for i = 0..23 on consecutive cycles -> bus_out follows one cycle later with src_id = i, contention stays 0, and xfer_count = 24 at the end.
- Contention: src_out = 24'h000024 (sources 2 and 5), data 32'h22222222 / 32'h55555555 -> bus_out = 32'h22222222, src_id = 2, contention = 1. The flag stays 1 after src_out returns to one-hot. Pulsing contention_clr with src_out = 0 clears it. contention_clr together with src_out = 24'h000003 leaves it at 1.
- Idle modes: after a transfer of 32'h12345678, set src_out = 0 -> HOLD_LAST = 0 gives bus_out = 0, and HOLD_LAST = 1 gives bus_out = 32'h12345678. In both modes bus_valid = 0 and src_id is unchanged.
- Counter saturation: CNTW = 4, hold src_out = 24'h800000 for 20 cycles -> xfer_count reaches 4'hF and stays there, and src_id = 23.
- Odd parameters: WIDTH = 8, NSRC = 5 -> SELW = 3. src_out = 5'b10000 with src_data[4] = 8'h9C gives bus_out = 8'h9C, src_id = 4.
